// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle control sequencer of the 16-bit
// TSC-style CPU: opcode/funct constants, FSM state enum, instruction classes,
// datapath select encodings, ALU operation codes and the instruction
// classifier used by the ID stage.
// -----------------------------------------------------------------------------
package mc_pkg;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Instruction classes latched at ID; they steer every later state
  typedef enum logic [3:0] {
    CL_NOP  = 4'd0,
    CL_JMP  = 4'd1,
    CL_JPR  = 4'd2,
    CL_WWD  = 4'd3,
    CL_HLT  = 4'd4,
    CL_JAL  = 4'd5,
    CL_JRL  = 4'd6,
    CL_BR   = 4'd7,
    CL_RALU = 4'd8,
    CL_IALU = 4'd9,
    CL_LWD  = 4'd10,
    CL_SWD  = 4'd11
  } iclass_t;

  // pc_src encodings
  localparam logic [1:0] PCS_INC = 2'd0;  // PC + 1
  localparam logic [1:0] PCS_BR  = 2'd1;  // PC + sext(imm)
  localparam logic [1:0] PCS_JMP = 2'd2;  // {PC[15:12], target}
  localparam logic [1:0] PCS_REG = 2'd3;  // rs

  // wb_sel encodings
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // reg_dst encodings
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_R2 = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] ASB_RT   = 2'd0;
  localparam logic [1:0] ASB_SIMM = 2'd1;
  localparam logic [1:0] ASB_ZIMM = 2'd2;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_NEG = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd10;
  localparam logic [3:0] ALU_BEQ = 4'd11;
  localparam logic [3:0] ALU_BGZ = 4'd12;
  localparam logic [3:0] ALU_BLZ = 4'd13;

  // Map opcode/funct to an instruction class; anything unrecognised is a NOP
  function automatic iclass_t classify(input logic [3:0] op, input logic [5:0] fn);
    iclass_t cls;
    case (op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls = CL_BR;
      OP_ADI, OP_ORI, OP_LHI:         cls = CL_IALU;
      OP_LWD:                         cls = CL_LWD;
      OP_SWD:                         cls = CL_SWD;
      OP_JMP:                         cls = CL_JMP;
      OP_JAL:                         cls = CL_JAL;
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: cls = CL_RALU;
          FN_JPR:                         cls = CL_JPR;
          FN_JRL:                         cls = CL_JRL;
          FN_WWD:                         cls = CL_WWD;
          FN_HLT:                         cls = CL_HLT;
          default:                        cls = CL_NOP;
        endcase
      end
      default: cls = CL_NOP;
    endcase
    return cls;
  endfunction

  // ALU B operand select for the EX state; ORI/LHI need the zero-extended immediate
  function automatic logic [1:0] alu_src_b_of(input iclass_t cls, input logic [3:0] op);
    logic [1:0] sel;
    case (cls)
      CL_IALU:        sel = (op == OP_ADI) ? ASB_SIMM : ASB_ZIMM;
      CL_LWD, CL_SWD: sel = ASB_SIMM;
      default:        sel = ASB_RT;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// -----------------------------------------------------------------------------
// mc_alu_decode
// Combinational ALU operation decoder.
//   opcode [3:0] : IR[15:12]
//   funct  [5:0] : IR[5:0]
//   alu_op [3:0] : ALU operation code (see mc_pkg ALU_*)
// Opcodes that do not use the ALU result decode to ALU_ADD.
// -----------------------------------------------------------------------------
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op
);

  // Opcode/funct to ALU operation
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_BNE:                 alu_op = ALU_BNE;
      OP_BEQ:                 alu_op = ALU_BEQ;
      OP_BGZ:                 alu_op = ALU_BGZ;
      OP_BLZ:                 alu_op = ALU_BLZ;
      OP_ADI, OP_LWD, OP_SWD: alu_op = ALU_ADD;
      OP_ORI:                 alu_op = ALU_OR;
      OP_LHI:                 alu_op = ALU_LHI;
      OP_RTYPE: begin
        // funct 0..7 line up one-to-one with ALU codes 0..7
        if (funct[5:3] == 3'b000) begin
          alu_op = {1'b0, funct[2:0]};
        end else begin
          alu_op = ALU_ADD;
        end
      end
      default:                alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_seq.sv
// -----------------------------------------------------------------------------
// mc_control_seq
// Multi-cycle control sequencer (IF/ID/EX/MEM/WB/HALT) for the 16-bit
// TSC-style CPU, with a ready-based memory handshake, a retired-instruction
// counter and a sticky halt state.
//   Clk, Reset_N          : clock, asynchronous active-low reset
//   opcode, funct         : instruction fields (stable from ID onward)
//   bcond                 : branch condition from the ALU, valid in EX
//   mem_ready             : memory completes the current access this cycle
//   read_m, write_m       : memory request strobes
//   i_or_d                : address select (0 = PC, 1 = ALU result)
//   ir_write, pc_write    : IR / PC load strobes; pc_src selects next PC
//   reg_write, reg_dst,
//   wb_sel                : register-file write controls
//   alu_src_b, alu_op     : ALU controls
//   out_write             : output port latch enable (WWD)
//   num_inst              : retired instruction count (wraps)
//   is_halted             : HLT has been executed
// Strobes are decoded from the registered state and the class latched at ID;
// the IF/MEM handshake and the branch decision also look at mem_ready/bcond
// so the strobes land in the very cycle the access or compare completes.
// -----------------------------------------------------------------------------
module mc_control_seq
  import mc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic [3:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             read_m,
  output logic             write_m,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             out_write,
  output logic [CNT_W-1:0] num_inst,
  output logic             is_halted
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // WORD_SIZE only documents the datapath width
  logic unused_word_size_s;
  assign unused_word_size_s = (WORD_SIZE > 0) ? 1'b1 : 1'b0;

  state_t           state_r;
  iclass_t          cls_r;
  logic [1:0]       asb_r;
  logic [3:0]       aop_r;
  logic [CNT_W-1:0] num_inst_r;

  iclass_t          cls_s;
  logic [1:0]       asb_s;
  logic [3:0]       aop_s;

  logic             read_m_s, write_m_s, i_or_d_s, ir_write_s, pc_write_s;
  logic             reg_write_s, out_write_s;
  logic [1:0]       pc_src_s, reg_dst_s, wb_sel_s, alu_src_b_s;
  logic [3:0]       alu_op_s;

  mc_alu_decode u_alu_decode (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (aop_s)
  );

  // Live decode of the freshly loaded instruction, used in ID and latched there
  always_comb begin
    cls_s = classify(opcode, funct);
    asb_s = alu_src_b_of(cls_s, opcode);
  end

  // Sequencer state, latched decode and retired-instruction counter
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_r    <= ST_IF;
      cls_r      <= CL_NOP;
      asb_r      <= ASB_RT;
      aop_r      <= ALU_ADD;
      num_inst_r <= '0;
    end else begin
      case (state_r)
        ST_IF: begin
          if (mem_ready) begin
            state_r <= ST_ID;
          end
        end
        ST_ID: begin
          cls_r <= cls_s;
          asb_r <= asb_s;
          aop_r <= aop_s;
          case (cls_s)
            CL_JMP, CL_JPR, CL_WWD, CL_NOP: begin
              state_r    <= ST_IF;
              num_inst_r <= num_inst_r + CNT_ONE;
            end
            CL_HLT: begin
              state_r    <= ST_HALT;
              num_inst_r <= num_inst_r + CNT_ONE;
            end
            CL_JAL, CL_JRL: state_r <= ST_WB;
            default:        state_r <= ST_EX;
          endcase
        end
        ST_EX: begin
          case (cls_r)
            CL_BR: begin
              state_r    <= ST_IF;
              num_inst_r <= num_inst_r + CNT_ONE;
            end
            CL_LWD, CL_SWD: state_r <= ST_MEM;
            default:        state_r <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (cls_r == CL_LWD) begin
              state_r <= ST_WB;
            end else begin
              state_r    <= ST_IF;
              num_inst_r <= num_inst_r + CNT_ONE;
            end
          end
        end
        ST_WB: begin
          state_r    <= ST_IF;
          num_inst_r <= num_inst_r + CNT_ONE;
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_IF;
      endcase
    end
  end

  // Datapath strobes; everything is held at 0 while reset is asserted
  always_comb begin
    read_m_s    = 1'b0;
    write_m_s   = 1'b0;
    i_or_d_s    = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_src_s    = PCS_INC;
    reg_write_s = 1'b0;
    reg_dst_s   = RD_RT;
    wb_sel_s    = WB_ALU;
    alu_src_b_s = ASB_RT;
    alu_op_s    = ALU_ADD;
    out_write_s = 1'b0;
    if (Reset_N) begin
      case (state_r)
        ST_IF: begin
          read_m_s = 1'b1;
          if (mem_ready) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            pc_src_s   = PCS_INC;
          end else begin
            ir_write_s = 1'b0;
          end
        end
        ST_ID: begin
          case (cls_s)
            CL_JMP: begin
              pc_write_s = 1'b1;
              pc_src_s   = PCS_JMP;
            end
            CL_JPR: begin
              pc_write_s = 1'b1;
              pc_src_s   = PCS_REG;
            end
            CL_WWD:  out_write_s = 1'b1;
            default: out_write_s = 1'b0;
          endcase
        end
        ST_EX: begin
          alu_op_s    = aop_r;
          alu_src_b_s = asb_r;
          if ((cls_r == CL_BR) && bcond) begin
            pc_write_s = 1'b1;
            pc_src_s   = PCS_BR;
          end else begin
            pc_write_s = 1'b0;
          end
        end
        ST_MEM: begin
          i_or_d_s = 1'b1;
          // Exactly one of read/write can be raised here
          if (cls_r == CL_LWD) begin
            read_m_s = 1'b1;
          end else if (cls_r == CL_SWD) begin
            write_m_s = 1'b1;
          end else begin
            read_m_s = 1'b0;
          end
        end
        ST_WB: begin
          reg_write_s = 1'b1;
          case (cls_r)
            CL_RALU: begin
              reg_dst_s = RD_RD;
              wb_sel_s  = WB_ALU;
            end
            CL_IALU: begin
              reg_dst_s = RD_RT;
              wb_sel_s  = WB_ALU;
            end
            CL_LWD: begin
              reg_dst_s = RD_RT;
              wb_sel_s  = WB_MEM;
            end
            CL_JAL: begin
              reg_dst_s  = RD_R2;
              wb_sel_s   = WB_PC;
              pc_write_s = 1'b1;
              pc_src_s   = PCS_JMP;
            end
            CL_JRL: begin
              reg_dst_s  = RD_R2;
              wb_sel_s   = WB_PC;
              pc_write_s = 1'b1;
              pc_src_s   = PCS_REG;
            end
            default: reg_dst_s = RD_RT;
          endcase
        end
        ST_HALT: read_m_s = 1'b0;
        default: read_m_s = 1'b0;
      endcase
    end else begin
      read_m_s = 1'b0;
    end
  end

  assign read_m    = read_m_s;
  assign write_m   = write_m_s;
  assign i_or_d    = i_or_d_s;
  assign ir_write  = ir_write_s;
  assign pc_write  = pc_write_s;
  assign pc_src    = pc_src_s;
  assign reg_write = reg_write_s;
  assign reg_dst   = reg_dst_s;
  assign wb_sel    = wb_sel_s;
  assign alu_src_b = alu_src_b_s;
  assign alu_op    = alu_op_s;
  assign out_write = out_write_s;
  assign num_inst  = num_inst_r;
  assign is_halted = (state_r == ST_HALT);

endmodule

// File: tb/tb_mc_control_seq.sv
// -----------------------------------------------------------------------------
// tb_mc_control_seq
// Self-checking bench for mc_control_seq. For each instruction the bench
// builds the expected per-cycle strobe trace from the instruction's rules
// (IF with wait states, ID, optional EX/MEM/WB), then drives the DUT one
// cycle per trace entry and compares. Counter width is reduced so the
// wrap-around case stays short.
// -----------------------------------------------------------------------------
module tb_mc_control_seq;

  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset_N = 1'b0;
  logic [3:0]    opcode = 4'd0;
  logic [5:0]    funct = 6'd0;
  logic          bcond = 1'b0;
  logic          mem_ready = 1'b1;
  logic          read_m, write_m, i_or_d, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          reg_write;
  logic [1:0]    reg_dst, wb_sel, alu_src_b;
  logic [3:0]    alu_op;
  logic          out_write;
  logic [CW-1:0] num_inst;
  logic          is_halted;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  mc_control_seq #(.WORD_SIZE(16), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .opcode(opcode), .funct(funct),
    .bcond(bcond), .mem_ready(mem_ready), .read_m(read_m), .write_m(write_m),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .out_write(out_write),
    .num_inst(num_inst), .is_halted(is_halted)
  );

  always #5 Clk = ~Clk;

  // One expected cycle. mr: -1 = drive random mem_ready, else drive that value.
  typedef struct {
    logic       rd, wr, iod, irw, pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rdst, wbs, asb;
    logic [3:0] aop;
    logic       ow, hlt;
    bit         ex, live;
    int         mr;
  } rec_t;

  function automatic rec_t blank();
    rec_t r;
    r = '{default: 0};
    r.mr = -1;
    return r;
  endfunction

  // Select fields only matter when their strobe (or EX) says so
  function automatic logic [19:0] pack(input rec_t r, input rec_t c);
    return {r.rd, r.wr, (c.rd | c.wr) ? r.iod : 1'b0, r.irw, r.pcw,
            c.pcw ? r.pcs : 2'b00, r.rw, c.rw ? r.rdst : 2'b00,
            c.rw ? r.wbs : 2'b00, c.ex ? r.asb : 2'b00,
            c.ex ? r.aop : 4'h0, r.ow, r.hlt};
  endfunction

  function automatic rec_t dut_rec();
    rec_t a;
    a = blank();
    a.rd = read_m;  a.wr = write_m; a.iod = i_or_d; a.irw = ir_write;
    a.pcw = pc_write; a.pcs = pc_src; a.rw = reg_write; a.rdst = reg_dst;
    a.wbs = wb_sel; a.asb = alu_src_b; a.aop = alu_op; a.ow = out_write;
    a.hlt = is_halted;
    return a;
  endfunction

  function automatic logic [3:0] exp_aop(input logic [3:0] op, input logic [5:0] fn);
    case (op)
      4'd0: return 4'd10;
      4'd1: return 4'd11;
      4'd2: return 4'd12;
      4'd3: return 4'd13;
      4'd5: return 4'd3;
      4'd6: return 4'd8;
      4'd15: return fn[3:0];
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [18:0] raw_strobes();
    return {read_m, write_m, i_or_d, ir_write, pc_write, pc_src, reg_write,
            reg_dst, wb_sel, alu_src_b, alu_op, out_write};
  endfunction

  // Build the expected trace of one instruction, then run and compare it
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn,
                           input logic bc, input int if_w, input int mem_w);
    rec_t  tr[$];
    rec_t  r, a;
    string tag;
    bit    is_br, is_ld, is_st, is_ialu, is_ralu;
    tag = $sformatf("op%0d_fn%0d", op, fn);
    r = blank(); r.rd = 1'b1; r.mr = 0;
    for (int i = 0; i < if_w; i++) tr.push_back(r);
    r.mr = 1; r.irw = 1'b1; r.pcw = 1'b1; r.pcs = 2'd0;
    tr.push_back(r);
    r = blank(); r.live = 1'b1;
    is_br   = (op <= 4'd3);
    is_ialu = (op >= 4'd4 && op <= 4'd6);
    is_ld   = (op == 4'd7);
    is_st   = (op == 4'd8);
    is_ralu = (op == 4'd15 && fn <= 6'd7);
    if (op == 4'd9) begin
      r.pcw = 1'b1; r.pcs = 2'd2; tr.push_back(r);
    end else if (op == 4'd15 && fn == 6'd25) begin
      r.pcw = 1'b1; r.pcs = 2'd3; tr.push_back(r);
    end else if (op == 4'd15 && fn == 6'd28) begin
      r.ow = 1'b1; tr.push_back(r);
    end else if (op == 4'd10 || (op == 4'd15 && fn == 6'd26)) begin
      tr.push_back(r);
      r.rw = 1'b1; r.rdst = 2'd2; r.wbs = 2'd2; r.pcw = 1'b1;
      r.pcs = (op == 4'd10) ? 2'd2 : 2'd3;
      tr.push_back(r);
    end else if (!(is_br || is_ialu || is_ld || is_st || is_ralu)) begin
      tr.push_back(r);  // HLT or unknown: retire straight from ID
    end else begin
      tr.push_back(r);
      r.ex = 1'b1; r.aop = exp_aop(op, fn);
      r.asb = (is_br || is_ralu) ? 2'd0 : ((op == 4'd5 || op == 4'd6) ? 2'd2 : 2'd1);
      if (is_br && bc) begin r.pcw = 1'b1; r.pcs = 2'd1; end
      tr.push_back(r);
      if (is_ld || is_st) begin
        r = blank(); r.live = 1'b1; r.rd = is_ld; r.wr = is_st; r.iod = 1'b1; r.mr = 0;
        for (int i = 0; i < mem_w; i++) tr.push_back(r);
        r.mr = 1; tr.push_back(r);
      end
      r = blank(); r.live = 1'b1; r.rw = 1'b1;
      if (is_ld)   begin r.rdst = 2'd0; r.wbs = 2'd1; tr.push_back(r); end
      if (is_ialu) begin r.rdst = 2'd0; r.wbs = 2'd0; tr.push_back(r); end
      if (is_ralu) begin r.rdst = 2'd1; r.wbs = 2'd0; tr.push_back(r); end
    end
    foreach (tr[i]) begin
      opcode    = tr[i].live ? op : 4'($urandom);
      funct     = tr[i].live ? fn : 6'($urandom);
      bcond     = tr[i].ex ? bc : 1'($urandom);
      mem_ready = (tr[i].mr < 0) ? 1'($urandom) : tr[i].mr[0];
      @(negedge Clk);
      a = dut_rec();
      checks++;
      if (pack(a, tr[i]) !== pack(tr[i], tr[i])) begin
        errors++;
        $display("FAIL %s cycle %0d: strobes got %05h expected %05h",
                 tag, i, pack(a, tr[i]), pack(tr[i], tr[i]));
      end
      @(posedge Clk); #1;
    end
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (num_inst !== exp_cnt) begin
      errors++;
      $display("FAIL %s num_inst: got %0d expected %0d", tag, num_inst, exp_cnt);
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 4'($urandom); funct = 6'($urandom);
      @(negedge Clk);
      checks++;
      if (raw_strobes() !== 19'd0 || num_inst !== '0 || is_halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: strobes %05h num_inst %0d halted %0b expected 0/0/0",
                 raw_strobes(), num_inst, is_halted);
      end
    end
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_adi_lwd();
    run_instr(4'd4, 6'd0, 1'b0, 0, 0);
    run_instr(4'd7, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_lwd_waits();
    run_instr(4'd7, 6'd0, 1'b0, 3, 2);
    run_instr(4'd8, 6'd0, 1'b0, 2, 3);
  endtask

  task automatic test_branch();
    run_instr(4'd1, 6'd0, 1'b1, 0, 0);
    run_instr(4'd1, 6'd0, 1'b0, 0, 0);
    run_instr(4'd0, 6'd0, 1'b1, 1, 0);
    run_instr(4'd3, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_jumps();
    run_instr(4'd15, 6'd26, 1'b0, 0, 0);
    run_instr(4'd10, 6'd0, 1'b0, 0, 0);
    run_instr(4'd9, 6'd0, 1'b0, 0, 0);
    run_instr(4'd15, 6'd25, 1'b0, 0, 0);
    run_instr(4'd15, 6'd28, 1'b0, 0, 0);
    run_instr(4'd12, 6'd0, 1'b0, 0, 0);
    run_instr(4'd15, 6'd30, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] fn_tab [12];
    logic [3:0] op;
    logic [5:0] fn;
    fn_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
               6'd25, 6'd26, 6'd28, 6'd40};
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      fn = (op == 4'd15) ? fn_tab[$urandom_range(0, 11)] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 300 && exp_cnt != {CW{1'b1}}; n++) begin
      run_instr(4'd15, 6'd28, 1'b0, 0, 0);
    end
    checks++;
    if (num_inst !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL wrap_preload: num_inst got %0d expected %0d", num_inst, {CW{1'b1}});
    end
    run_instr(4'd15, 6'd28, 1'b0, 0, 0);
    checks++;
    if (num_inst !== '0) begin
      errors++;
      $display("FAIL wrap_zero: num_inst got %0d expected 0", num_inst);
    end
  endtask

  task automatic test_reset_mid_if();
    run_instr(4'd4, 6'd0, 1'b0, 0, 0);
    mem_ready = 1'b0;
    @(negedge Clk);
    checks++;
    if (read_m !== 1'b1) begin
      errors++;
      $display("FAIL if_wait_read: read_m got %0b expected 1", read_m);
    end
    #2 Reset_N = 1'b0;
    #1;
    checks++;
    if (read_m !== 1'b0 || num_inst !== '0) begin
      errors++;
      $display("FAIL mid_if_reset: read_m %0b num_inst %0d expected 0/0", read_m, num_inst);
    end
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    exp_cnt = '0;
    run_instr(4'd15, 6'd1, 1'b0, 1, 0);
  endtask

  task automatic test_halt();
    run_instr(4'd15, 6'd29, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom); opcode = 4'($urandom);
      funct = 6'($urandom); bcond = 1'($urandom);
      @(negedge Clk);
      checks++;
      if (raw_strobes() !== 19'd0 || is_halted !== 1'b1 || num_inst !== exp_cnt) begin
        errors++;
        $display("FAIL halt_cycle %0d: strobes %05h halted %0b num_inst %0d expected 0/1/%0d",
                 i, raw_strobes(), is_halted, num_inst, exp_cnt);
      end
      @(posedge Clk); #1;
    end
    Reset_N = 1'b0;
    #2;
    checks++;
    if (num_inst !== '0 || is_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: num_inst %0d halted %0b expected 0/0", num_inst, is_halted);
    end
    @(posedge Clk); #1;
    Reset_N = 1'b1;
    exp_cnt = '0;
    run_instr(4'd5, 6'd0, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_adi_lwd();
    test_lwd_waits();
    test_branch();
    test_jumps();
    test_random();
    test_wrap();
    test_reset_mid_if();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
